// File: rtl/icache_refill_axi.sv
// icache_refill_axi: instruction-cache line refill engine (read-only AXI4 master).
//
// On a line-fill request it issues one INCR burst of BEATS x 32-bit beats for the line.
// It packs the returned beats into a LINE_WD-bit line. It then presents the line to the
// cache with a single-cycle reload pulse.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   rd_req, rd_addr   line-fill request and line address from the icache
//   reload            one-cycle pulse, cacheline_new valid
//   cacheline_new     assembled line, beat k at [32k+31:32k]
//   busy              engine is not idle
//   ar*               AXI4 read address channel (master side)
//   r*                AXI4 read data channel (master side)
module icache_refill_axi #(
    parameter logic [3:0]  AXI_ID  = 4'h0,
    parameter int unsigned BEATS   = 16,
    parameter int unsigned LINE_WD = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_req,
    input  logic [31:0]        rd_addr,
    output logic               reload,
    output logic [LINE_WD-1:0] cacheline_new,
    output logic               busy,
    output logic [3:0]         arid,
    output logic [31:0]        araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [3:0]         rid,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready
);

    localparam int unsigned CNT_WD = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

    state_e              state_q, state_d;
    logic [25:0]         line_addr_q, line_addr_d;
    logic [CNT_WD-1:0]   beat_q, beat_d;
    logic [LINE_WD-1:0]  line_q, line_d;
    logic                beat_ok;
    logic                unused_inputs;

    // Response code and rlast play no part: the burst ends by beat count.
    assign unused_inputs = ^{rresp, rlast, rd_addr[5:0]};

    // Beats carrying a foreign ID are still acknowledged (rready is high) but never stored.
    assign beat_ok = (state_q == StR) && rvalid && (rid == AXI_ID);

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        beat_d      = beat_q;
        line_d      = line_q;
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    line_addr_d = rd_addr[31:6];
                    beat_d      = '0;
                    state_d     = StAr;
                end
            end
            StAr: begin
                if (arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (beat_ok) begin
                    for (int k = 0; k < int'(BEATS); k++) begin
                        if (beat_q == CNT_WD'(k)) begin
                            line_d[32*k +: 32] = rdata;
                        end
                    end
                    beat_d = beat_q + CNT_WD'(1);
                    if (beat_q == CNT_WD'(BEATS - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            // rd_req may still be high here (tag not yet written); it is not re-sampled.
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            line_addr_q <= '0;
            beat_q      <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
        end
    end

    // All handshake outputs decode the registered state: no arready -> arvalid path.
    assign arvalid       = (state_q == StAr);
    assign rready        = (state_q == StR);
    assign reload        = (state_q == StDone);
    assign busy          = (state_q != StIdle);
    assign araddr        = {line_addr_q, 6'b0};
    assign arid          = AXI_ID;
    assign arlen         = 8'(BEATS - 1);
    assign arsize        = 3'b010;
    assign arburst       = 2'b01;
    assign cacheline_new = line_q;

endmodule

// File: tb/tb_icache_refill_axi.sv
// Testbench for icache_refill_axi: randomized AXI slave behaviour against a line model.
module tb_icache_refill_axi;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         reload;
    logic [511:0] cacheline_new;
    logic         busy;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    always #5 clk = ~clk;

    icache_refill_axi dut (
        .clk           (clk),
        .reset         (reset),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .reload        (reload),
        .cacheline_new (cacheline_new),
        .busy          (busy),
        .arid          (arid),
        .araddr        (araddr),
        .arlen         (arlen),
        .arsize        (arsize),
        .arburst       (arburst),
        .arvalid       (arvalid),
        .arready       (arready),
        .rid           (rid),
        .rdata         (rdata),
        .rresp         (rresp),
        .rlast         (rlast),
        .rvalid        (rvalid),
        .rready        (rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observations from the last fill
    int           o_first_ar, o_reload_cycle, o_ar_hs, o_last_acc;
    bit           o_timeout, o_ar_bad, o_hold_bad, o_after_bad;
    logic [31:0]  o_araddr;
    logic [511:0] o_line;
    // Reference model: line built from accepted beats, and the line the cache last saw
    logic [511:0] exp_line, prev_line;

    // Acts as the icache plus an AXI slave for one refill. Cycle 0 is the edge sampling rd_req.
    task automatic fill(input logic [31:0] addr, input int ar_wait, input int rv_pct,
                        input int n_foreign, input int drop_at, input int abort_at,
                        input bit count_pat);
        int acc;
        int fsent;
        int ar_cnt;
        logic [31:0] line_base;
        line_base      = {addr[31:6], 6'b0};
        o_first_ar     = -1;
        o_reload_cycle = -1;
        o_ar_hs        = 0;
        o_last_acc     = -1;
        o_timeout      = 1;
        o_ar_bad       = 0;
        o_hold_bad     = 0;
        o_after_bad    = 0;
        o_araddr       = 'x;
        o_line         = 'x;
        exp_line       = '0;
        acc            = 0;
        fsent          = 0;
        ar_cnt         = 0;
        rd_req         = 1'b1;
        rd_addr        = addr;
        arready        = 1'b0;
        rvalid         = 1'b0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(posedge clk);
            #1;
            if (drop_at > 0 && cyc >= drop_at) rd_req = 1'b0;
            rd_addr = $urandom;
            if (acc == 0 && cacheline_new !== prev_line) o_hold_bad = 1;
            if (reload) begin
                o_reload_cycle = cyc;
                o_line         = cacheline_new;
                o_timeout      = 0;
                arready        = 1'b0;
                rvalid         = 1'b0;
                @(posedge clk);
                #1;
                if (reload !== 1'b0 || busy !== 1'b0 || arvalid !== 1'b0) o_after_bad = 1;
                rd_req = 1'b0;
                return;
            end
            if (arvalid) begin
                if (o_first_ar < 0) begin
                    o_first_ar = cyc;
                    o_araddr   = araddr;
                end
                if (araddr !== line_base || arlen !== 8'd15 || arsize !== 3'd2 ||
                    arburst !== 2'd1 || arid !== 4'h0 || rready !== 1'b0) o_ar_bad = 1;
                arready = (ar_cnt >= ar_wait);
                if (arready) o_ar_hs++;
                ar_cnt++;
            end else begin
                arready = 1'($urandom_range(0, 1));
            end
            if (rready) begin
                rid    = 4'h0;
                rvalid = 1'b0;
                rdata  = $urandom;
                if (acc < 16) begin
                    if (fsent < n_foreign && ($urandom_range(0, 3) == 0 || acc >= 8)) begin
                        rvalid = 1'b1;
                        rid    = 4'h3;
                        fsent++;
                    end else if (int'($urandom_range(0, 99)) < rv_pct) begin
                        rvalid = 1'b1;
                        if (count_pat) rdata = acc;
                        exp_line[acc*32 +: 32] = rdata;
                        acc++;
                        o_last_acc = cyc;
                    end
                end
            end else begin
                // Stray valid data while rready is low must not land in the line.
                rvalid = 1'($urandom_range(0, 1));
                rid    = 4'h0;
                rdata  = $urandom;
            end
            if (abort_at > 0 && acc == abort_at) begin
                o_timeout = 0;
                return;
            end
        end
        $display("FAIL fill_timeout: no reload within 300 cycles for addr %h", addr);
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 32'h1234_5678;
        arready = 1'b1;
        rvalid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({arvalid, rready, reload, busy} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {arvalid, rready, reload, busy});
        end
        n_cmp++; if (araddr !== 32'h0) begin
            n_bad++; $display("FAIL reset_araddr: got %h want 0", araddr);
        end
        n_cmp++; if (cacheline_new !== 512'h0) begin
            n_bad++; $display("FAIL reset_line: got %h want 0", cacheline_new);
        end
        reset   = 1'b0;
        rd_req  = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        prev_line = '0;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic;
        logic [511:0] golden;
        for (int k = 0; k < 16; k++) golden[k*32 +: 32] = k;
        fill(32'hBFC0_0124, 0, 100, 0, 0, 0, 1'b1);
        n_cmp++; if (o_timeout !== 1'b0) begin
            n_bad++; $display("FAIL basic_done: got timeout %b want 0", o_timeout);
        end
        n_cmp++; if (o_araddr !== 32'hBFC0_0100) begin
            n_bad++; $display("FAIL basic_araddr: got %h want bfc00100", o_araddr);
        end
        n_cmp++; if (o_first_ar !== 1) begin
            n_bad++; $display("FAIL basic_ar_cycle: got %0d want 1", o_first_ar);
        end
        n_cmp++; if (o_ar_bad !== 1'b0 || o_ar_hs !== 1) begin
            n_bad++; $display("FAIL basic_ar_fields: got bad=%b hs=%0d want 0/1", o_ar_bad, o_ar_hs);
        end
        n_cmp++; if (o_reload_cycle !== 18) begin
            n_bad++; $display("FAIL basic_reload_cycle: got %0d want 18", o_reload_cycle);
        end
        n_cmp++; if (o_line !== golden) begin
            n_bad++; $display("FAIL basic_line: got %h want %h", o_line, golden);
        end
        n_cmp++; if (o_after_bad !== 1'b0 || o_hold_bad !== 1'b0) begin
            n_bad++; $display("FAIL basic_pulse_hold: got after=%b hold=%b want 0/0", o_after_bad, o_hold_bad);
        end
        prev_line = golden;
    endtask

    task automatic test_backpressure;
        logic [31:0] addr;
        for (int it = 0; it < 3; it++) begin
            addr = $urandom;
            fill(addr, 3, 50, 0, 0, 0, 1'b0);
            n_cmp++; if (o_ar_bad !== 1'b0 || o_ar_hs !== 1 || o_first_ar !== 1) begin
                n_bad++; $display("FAIL bp_ar: got bad=%b hs=%0d first=%0d want 0/1/1", o_ar_bad, o_ar_hs, o_first_ar);
            end
            n_cmp++; if (o_araddr !== {addr[31:6], 6'b0}) begin
                n_bad++; $display("FAIL bp_araddr: got %h want %h", o_araddr, {addr[31:6], 6'b0});
            end
            n_cmp++; if (o_timeout !== 1'b0 || o_reload_cycle !== o_last_acc + 1) begin
                n_bad++; $display("FAIL bp_reload_cycle: got %0d want %0d", o_reload_cycle, o_last_acc + 1);
            end
            n_cmp++; if (o_line !== exp_line) begin
                n_bad++; $display("FAIL bp_line: got %h want %h", o_line, exp_line);
            end
            n_cmp++; if (o_after_bad !== 1'b0 || o_hold_bad !== 1'b0) begin
                n_bad++; $display("FAIL bp_pulse_hold: got after=%b hold=%b want 0/0", o_after_bad, o_hold_bad);
            end
            prev_line = exp_line;
        end
    endtask

    task automatic test_foreign_id;
        fill($urandom, 0, 100, 2, 0, 0, 1'b0);
        // Zero-wait slave: each dropped foreign beat delays reload by one cycle.
        n_cmp++; if (o_reload_cycle !== 20) begin
            n_bad++; $display("FAIL foreign_reload_cycle: got %0d want 20", o_reload_cycle);
        end
        n_cmp++; if (o_line !== exp_line) begin
            n_bad++; $display("FAIL foreign_line: got %h want %h", o_line, exp_line);
        end
        n_cmp++; if (o_after_bad !== 1'b0 || o_hold_bad !== 1'b0) begin
            n_bad++; $display("FAIL foreign_pulse_hold: got after=%b hold=%b want 0/0", o_after_bad, o_hold_bad);
        end
        prev_line = exp_line;
    endtask

    task automatic test_request_drop;
        bit stray;
        fill($urandom, 0, 70, 0, 5, 0, 1'b0);
        n_cmp++; if (o_timeout !== 1'b0 || o_reload_cycle !== o_last_acc + 1) begin
            n_bad++; $display("FAIL drop_reload: got cycle %0d want %0d", o_reload_cycle, o_last_acc + 1);
        end
        n_cmp++; if (o_line !== exp_line) begin
            n_bad++; $display("FAIL drop_line: got %h want %h", o_line, exp_line);
        end
        stray = o_after_bad;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (arvalid !== 1'b0 || busy !== 1'b0) stray = 1;
        end
        n_cmp++; if (stray !== 1'b0) begin
            n_bad++; $display("FAIL drop_no_new_ar: got activity=%b want 0", stray);
        end
        prev_line = exp_line;
    endtask

    task automatic test_back_to_back;
        fill($urandom, 0, 100, 0, 0, 0, 1'b0);
        n_cmp++; if (o_after_bad !== 1'b0) begin
            n_bad++; $display("FAIL b2b_no_ar_after_done: got after=%b want 0", o_after_bad);
        end
        prev_line = exp_line;
        @(posedge clk);
        #1;
        n_cmp++; if (arvalid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle_gap: got arvalid %b want 0", arvalid);
        end
        fill(32'h0000_1040, 0, 60, 0, 0, 0, 1'b0);
        n_cmp++; if (o_araddr !== 32'h0000_1040 || o_first_ar !== 1) begin
            n_bad++; $display("FAIL b2b_araddr: got %h at %0d want 00001040 at 1", o_araddr, o_first_ar);
        end
        n_cmp++; if (o_hold_bad !== 1'b0) begin
            n_bad++; $display("FAIL b2b_line_hold: got hold_bad %b want 0", o_hold_bad);
        end
        n_cmp++; if (o_line !== exp_line) begin
            n_bad++; $display("FAIL b2b_line: got %h want %h", o_line, exp_line);
        end
        prev_line = exp_line;
    endtask

    task automatic test_reset_mid;
        logic [31:0] addr;
        fill($urandom, 0, 100, 0, 0, 7, 1'b0);
        n_cmp++; if (o_timeout !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_reach: got timeout %b want 0", o_timeout);
        end
        reset  = 1'b1;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        rvalid = 1'b0;
        n_cmp++; if ({arvalid, rready, reload, busy} !== 4'b0) begin
            n_bad++; $display("FAIL rstmid_ctrl: got %b want 0000", {arvalid, rready, reload, busy});
        end
        n_cmp++; if (cacheline_new !== 512'h0 || araddr !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_data: got line %h araddr %h want 0", cacheline_new, araddr);
        end
        prev_line = '0;
        addr = $urandom;
        fill(addr, 0, 100, 0, 0, 0, 1'b0);
        n_cmp++; if (o_reload_cycle !== 18 || o_araddr !== {addr[31:6], 6'b0}) begin
            n_bad++; $display("FAIL rstmid_refill: got cycle %0d araddr %h want 18 %h", o_reload_cycle, o_araddr, {addr[31:6], 6'b0});
        end
        n_cmp++; if (o_line !== exp_line || o_hold_bad !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_line: got %h want %h", o_line, exp_line);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rd_req    = 1'b0;
        rd_addr   = '0;
        arready   = 1'b0;
        rid       = '0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        prev_line = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_foreign_id();
        test_request_drop();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_refill_axi.md
Name: icache_refill_axi

Overview:
- Refill engine directly downstream of the instruction cache miss path.
- Accepts a line-fill request (rd_req/rd_addr) and issues one AXI4 INCR read burst of 16 x 32-bit beats for the 64-byte line.
- Assembles the beats into a 512-bit line and returns it to the cache with a one-cycle reload pulse.
- Read-only master: owns the AR and R channels only.

Parameters:
- AXI_ID, 4'h0, ARID driven on requests; only R beats with RID equal to this are consumed into the line.
- BEATS, 16, beats per line; ARLEN = BEATS-1.
- LINE_WD, 512, line width = BEATS*32.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  line-fill request from icache; level, held while miss persists.
- rd_addr  in  32  line address from icache (bits [5:0] treated as zero).
- reload  out  1  one-cycle pulse: cacheline_new valid, cache writes tag+data this edge.
- cacheline_new  out  512  assembled line; beat k at bits [32k+31:32k].
- busy  out  1  high in any state other than IDLE.
- arid  out  4  = AXI_ID.
- araddr  out  32  {latched rd_addr[31:6], 6'b0}.
- arlen  out  8  constant BEATS-1 (8'd15).
- arsize  out  3  constant 3'b010 (4 bytes).
- arburst  out  2  constant 2'b01 (INCR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R id.
- rdata  in  32  R data.
- rresp  in  2  R response (not checked).
- rlast  in  1  R last (informational only).
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset (synchronous, active-high, has priority over all events): state=IDLE, arvalid=0, rready=0, reload=0, busy=0, araddr=0, beat counter=0, cacheline_new=0.
- FSM states: IDLE, AR, R, DONE.
- IDLE: when rd_req=1, latch {rd_addr[31:6],6'b0} into araddr, clear beat counter, go to AR. rd_req=0 stays in IDLE.
- AR: arvalid=1; araddr, arlen, arsize, arburst and arid are stable. On arvalid&arready, arvalid drops next cycle and the FSM goes to R. No combinational path from arready to arvalid.
- R: rready=1.
  - A beat is accepted on rvalid&rready&(rid==AXI_ID).
  - Beats with a mismatching rid are acknowledged (rready high) and dropped; they are not counted.
  - Accepted beat k (counter value) is written to cacheline_new[32k+:32], then the counter increments.
  - On the 16th accepted beat (counter==15), go to DONE. Termination is by count; rlast is ignored.
- DONE: reload=1 for exactly this cycle, rready=0, then IDLE.
- cacheline_new is held stable from DONE until the first beat of the next refill is accepted.
- Latency, zero-wait slave: rd_req seen in IDLE at cycle 0; arvalid at cycle 1; beats at cycles 2..17; reload at cycle 18. reload therefore arrives at least 18 cycles after the request edge.
- Request dropped mid-refill (rd_req falls, e.g. fetch redirect): the burst is not aborted; it completes and reload is still pulsed. The cache must tolerate this.
- Re-request: rd_req is sampled only in IDLE. In the DONE cycle rd_req may still be high, because the tag is not yet written; this is not re-accepted. The cycle after DONE the cache hits and rd_req is low.
- rd_addr changing while busy: ignored; the latched araddr is used.
- At most one outstanding burst; no read interleaving is required.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. Beats still in flight at the interconnect are the system's responsibility; the interconnect shares the same reset.

Test Plan:
- Basic fill: rd_req=1, rd_addr=32'hBFC0_0124, arready=1, rvalid every cycle, rdata=beat index k -> araddr=32'hBFC0_0100, arlen=15, arsize=2, arburst=1; reload at cycle 18 for exactly 1 cycle; cacheline_new[32k+:32]=k for k=0..15.
- Backpressure: arready held 0 for 3 cycles, then rvalid toggling 1/0 -> arvalid stays high with stable araddr until the handshake; only 16 valid beats are captured, in order; reload occurs once.
- Foreign ID: 2 beats with rid=4'h3 interleaved among 16 with rid=AXI_ID -> the foreign beats are dropped, the line equals the 16 matching beats, reload occurs after the 16th matching beat.
- Request drop: rd_req falls at cycle 5 mid-burst -> the burst completes and reload still pulses; no new AR is issued afterwards while rd_req=0.
- Back-to-back: rd_req held high through DONE, then a new rd_req for address 32'h0000_1040 two cycles after reload -> no AR is issued in the DONE cycle; second AR araddr=32'h0000_1040; the previous line is held until the new first beat.
- Reset at beat 7: reset=1 for one cycle -> next cycle state=IDLE, arvalid=rready=reload=busy=0, cacheline_new=0; a fresh rd_req after reset completes normally.
